// File: rtl/adpcm_main_udiv_27ns_13ns_15_seq.sv
// Sequential unsigned restoring divider (27b / 13b) with an ap_start/ap_done handshake.
// One quotient bit per cycle; the quotient is saturated to quot_WIDTH bits and the remainder is exact.
module adpcm_main_udiv_27ns_13ns_15_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 27,
  parameter int din1_WIDTH = 13,
  parameter int quot_WIDTH = 15,
  parameter int rem_WIDTH  = 13
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ap_idle,
  output logic                  ap_done,
  output logic [quot_WIDTH-1:0] dout_quot,
  output logic [rem_WIDTH-1:0]  dout_rem,
  output logic                  overflow,
  output logic                  div_by_zero
);

  if (ID < 0 || rem_WIDTH != din1_WIDTH || quot_WIDTH >= din0_WIDTH) begin : g_bad_params
    $error("adpcm udiv: illegal parameter combination");
  end

  localparam int                CNT_W    = $clog2(din0_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(din0_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [din0_WIDTH-1:0] r_q;      // dividend shifts out the top, quotient shifts in the bottom
  logic [din1_WIDTH-1:0] r_d;
  logic [rem_WIDTH-1:0]  r_r;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_dbz;

  logic                  r_done;
  logic [quot_WIDTH-1:0] r_quot;
  logic [rem_WIDTH-1:0]  r_rem;
  logic                  r_ovf;
  logic                  r_dbz_out;

  logic [rem_WIDTH:0]    w_t;
  logic                  w_ge;
  logic [rem_WIDTH-1:0]  w_sub;
  logic                  w_ovf;

  // The partial remainder is always below the divisor, so the difference fits in rem_WIDTH bits.
  assign w_t   = {r_r, r_q[din0_WIDTH-1]};
  assign w_ge  = (w_t >= {1'b0, r_d});
  assign w_sub = w_t[rem_WIDTH-1:0] - r_d;
  assign w_ovf = |r_q[din0_WIDTH-1:quot_WIDTH];

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: default assigned first so no path through the case leaves w_state_nxt unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (ap_start) w_state_nxt = (din1 == '0) ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values of its peers.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_q       <= '0;
      r_d       <= '0;
      r_r       <= '0;
      r_cnt     <= '0;
      r_dbz     <= 1'b0;
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_ovf     <= 1'b0;
      r_dbz_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ap_start) begin
            r_q   <= din0;
            r_d   <= din1;
            r_r   <= '0;
            r_cnt <= CNT_LAST;
            r_dbz <= (din1 == '0);
          end
        end
        S_CALC: begin
          r_q <= {r_q[din0_WIDTH-2:0], w_ge};
          r_r <= w_ge ? w_sub : w_t[rem_WIDTH-1:0];
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_ONE;
        end
        S_DONE: begin
          r_done <= 1'b1;
          if (r_dbz) begin
            // Divide by zero never enters CALC, so r_q still holds the captured dividend.
            r_quot    <= '1;
            r_rem     <= r_q[rem_WIDTH-1:0];
            r_ovf     <= 1'b0;
            r_dbz_out <= 1'b1;
          end else begin
            r_quot    <= w_ovf ? {quot_WIDTH{1'b1}} : r_q[quot_WIDTH-1:0];
            r_rem     <= r_r;
            r_ovf     <= w_ovf;
            r_dbz_out <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ap_idle     = (r_state == S_IDLE);
  assign ap_done     = r_done;
  assign dout_quot   = r_quot;
  assign dout_rem    = r_rem;
  assign overflow    = r_ovf;
  assign div_by_zero = r_dbz_out;

endmodule

// File: tb/tb_adpcm_main_udiv_27ns_13ns_15_seq.sv
// Self-checking bench for the sequential divider: a reference model pushes expected results
// into a scoreboard at each accept edge; results are popped and compared when ap_done appears.
module tb_adpcm_main_udiv_27ns_13ns_15_seq;

  logic        clk;
  logic        rst;
  logic        ap_start;
  logic [26:0] din0;
  logic [12:0] din1;
  logic        ap_idle;
  logic        ap_done;
  logic [14:0] dout_quot;
  logic [12:0] dout_rem;
  logic        overflow;
  logic        div_by_zero;

  adpcm_main_udiv_27ns_13ns_15_seq #(
    .ID(1), .din0_WIDTH(27), .din1_WIDTH(13), .quot_WIDTH(15), .rem_WIDTH(13)
  ) dut (
    .ap_clk     (clk),
    .ap_rst     (rst),
    .ap_start   (ap_start),
    .din0       (din0),
    .din1       (din1),
    .ap_idle    (ap_idle),
    .ap_done    (ap_done),
    .dout_quot  (dout_quot),
    .dout_rem   (dout_rem),
    .overflow   (overflow),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [14:0] quot;
    logic [12:0] rem;
    logic        ovf;
    logic        dbz;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t model(input logic [26:0] a, input logic [12:0] b, input int due);
    exp_t m;
    longint unsigned la, lb, q;
    la = 64'(a);
    lb = 64'(b);
    m.due = due;
    if (lb == 0) begin
      m.quot = 15'h7FFF;
      m.rem  = a[12:0];
      m.ovf  = 1'b0;
      m.dbz  = 1'b1;
    end else begin
      q      = la / lb;
      m.rem  = 13'(la % lb);
      m.ovf  = (q > 64'd32767);
      m.quot = m.ovf ? 15'h7FFF : 15'(q);
      m.dbz  = 1'b0;
    end
    return m;
  endfunction

  // Runs one isolated operation and compares result, latency and pulse width.
  task automatic do_op(input logic [26:0] a, input logic [12:0] b, input string tag);
    exp_t e;
    int   e0;
    bit   got;
    @(negedge clk);
    din0     = a;
    din1     = b;
    ap_start = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    sb.push_back(model(a, b, e0 + ((b == 13'd0) ? 1 : 28)));
    @(negedge clk);
    ap_start = 1'b0;
    din0     = 27'($urandom);
    din1     = 13'($urandom);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (ap_done) got = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!got) begin
      $display("FAIL %s timeout: no ap_done within 40 cycles, required one", tag);
      void'(sb.pop_front());
      return;
    end
    n_pass++;
    e = sb.pop_front();
    n_checks++;
    if (cyc !== e.due) $display("FAIL %s latency: done at E0+%0d, required E0+%0d", tag, cyc - e0, e.due - e0);
    else n_pass++;
    n_checks++;
    if (dout_quot !== e.quot) $display("FAIL %s quot: got %0d required %0d", tag, dout_quot, e.quot);
    else n_pass++;
    n_checks++;
    if (dout_rem !== e.rem) $display("FAIL %s rem: got %0d required %0d", tag, dout_rem, e.rem);
    else n_pass++;
    n_checks++;
    if (overflow !== e.ovf) $display("FAIL %s overflow: got %b required %b", tag, overflow, e.ovf);
    else n_pass++;
    n_checks++;
    if (div_by_zero !== e.dbz) $display("FAIL %s div_by_zero: got %b required %b", tag, div_by_zero, e.dbz);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (ap_done !== 1'b0) $display("FAIL %s done_pulse: ap_done got %b one cycle later, required 0", tag, ap_done);
    else n_pass++;
  endtask

  task automatic test_reset();
    int n_done;
    rst = 1'b1;
    ap_start = 1'b0;
    din0 = '0;
    din1 = '0;
    #1;
    n_checks++;
    if ({ap_idle, ap_done, dout_quot, dout_rem, overflow, div_by_zero} !== {1'b1, 1'b0, 15'd0, 13'd0, 1'b0, 1'b0})
      $display("FAIL reset_por: idle=%b done=%b quot=%0d rem=%0d ovf=%b dbz=%b, required idle=1 rest 0",
               ap_idle, ap_done, dout_quot, dout_rem, overflow, div_by_zero);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_op(27'h1234567, 13'd0, "pre_reset_dbz");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (ap_idle !== 1'b1) $display("FAIL reset_async idle: got %b required 1", ap_idle);
    else n_pass++;
    n_checks++;
    if (dout_quot !== 15'd0) $display("FAIL reset_async quot: got %0d required 0", dout_quot);
    else n_pass++;
    n_checks++;
    if (dout_rem !== 13'd0) $display("FAIL reset_async rem: got %0d required 0", dout_rem);
    else n_pass++;
    n_checks++;
    if ({ap_done, overflow, div_by_zero} !== 3'b000)
      $display("FAIL reset_async flags: done/ovf/dbz got %b required 000", {ap_done, overflow, div_by_zero});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ap_done) n_done++;
    end
    n_checks++;
    if (n_done != 0) $display("FAIL reset_idle_quiet: %0d ap_done pulses without start, required 0", n_done);
    else n_pass++;
  endtask

  task automatic test_basic();
    do_op(27'd100000, 13'd7, "basic");
    do_op(27'd0, 13'd5, "zero_dividend");
    do_op(27'd12, 13'd13, "dividend_below_divisor");
  endtask

  task automatic test_max_operands();
    do_op(27'd134217727, 13'd8191, "max_operands");
  endtask

  task automatic test_overflow();
    do_op(27'd67108864, 13'd1, "overflow_2p26");
    do_op(27'd32767, 13'd1, "quot_at_limit");
    do_op(27'd32768, 13'd1, "quot_limit_plus1");
    do_op(27'd134217727, 13'd3, "overflow_exact_rem");
  endtask

  task automatic test_div_by_zero();
    do_op(27'h1234567, 13'd0, "div_by_zero");
  endtask

  task automatic test_random();
    logic [26:0] a;
    logic [12:0] b;
    for (int i = 0; i < 6; i++) begin
      a = 27'($urandom);
      b = 13'($urandom_range(1, 8191));
      do_op(a, b, $sformatf("random_%0d", i));
    end
  endtask

  // ap_start held high with operands changing every cycle; the bench predicts accept edges itself.
  task automatic test_back_to_back();
    localparam int K = 6;
    fork
      begin : driver
        int next_acc;
        int nacc;
        @(negedge clk);
        din0     = 27'($urandom);
        din1     = 13'd0;
        ap_start = 1'b1;
        next_acc = cyc + 1;
        nacc     = 0;
        while (nacc < K) begin
          @(posedge clk);
          #1;
          if (cyc == next_acc) begin
            sb.push_back(model(din0, din1, cyc + ((din1 == 13'd0) ? 1 : 28)));
            next_acc = cyc + ((din1 == 13'd0) ? 2 : 29);
            nacc++;
          end
          @(negedge clk);
          din0 = 27'($urandom);
          din1 = ($urandom_range(0, 9) == 0) ? 13'd0 : 13'($urandom_range(1, 8191));
        end
        ap_start = 1'b0;
      end
      begin : monitor
        exp_t e;
        int   seen;
        seen = 0;
        for (int i = 0; i < 400 && seen < K; i++) begin
          @(negedge clk);
          if (ap_done) begin
            seen++;
            n_checks++;
            if (sb.size() == 0) begin
              $display("FAIL b2b unexpected_done: ap_done at cycle %0d with empty scoreboard", cyc);
            end else begin
              e = sb.pop_front();
              if (cyc !== e.due || dout_quot !== e.quot || dout_rem !== e.rem ||
                  overflow !== e.ovf || div_by_zero !== e.dbz)
                $display("FAIL b2b result %0d: cyc=%0d quot=%0d rem=%0d ovf=%b dbz=%b, required cyc=%0d quot=%0d rem=%0d ovf=%b dbz=%b",
                         seen, cyc, dout_quot, dout_rem, overflow, div_by_zero,
                         e.due, e.quot, e.rem, e.ovf, e.dbz);
              else n_pass++;
            end
          end
        end
        n_checks++;
        if (seen != K) $display("FAIL b2b count: saw %0d results, required %0d", seen, K);
        else n_pass++;
      end
    join
    sb.delete();
  endtask

  task automatic test_abort();
    int e0;
    int n_done;
    @(negedge clk);
    din0     = 27'd100000;
    din1     = 13'd7;
    ap_start = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    @(negedge clk);
    ap_start = 1'b0;
    while (cyc < e0 + 10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({ap_idle, dout_quot, dout_rem, overflow, div_by_zero} !== {1'b1, 15'd0, 13'd0, 1'b0, 1'b0})
      $display("FAIL abort_reset: idle=%b quot=%0d rem=%0d ovf=%b dbz=%b, required idle=1 rest 0",
               ap_idle, dout_quot, dout_rem, overflow, div_by_zero);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ap_done) n_done++;
    end
    n_checks++;
    if (n_done != 0) $display("FAIL abort_no_done: %0d ap_done pulses after abort, required 0", n_done);
    else n_pass++;
    do_op(27'd98765432, 13'd4321, "after_abort");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_operands();
    test_overflow();
    test_div_by_zero();
    test_random();
    test_back_to_back();
    do_op(27'd99999, 13'd100, "after_b2b");
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
